// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor with BTB for a five-stage MIPS pipeline.
// Looked up in IF, updated from MEM; a sweep FSM clears the table after reset.
module branch_predictor #(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MODE     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_uncond,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned ENTRIES = 2 ** IDX_BITS;
  localparam logic [CTR_BITS-1:0] CtrMax = '1;
  localparam logic [CTR_BITS-1:0] CtrWt  = CTR_BITS'(2 ** (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CtrWnt = CTR_BITS'(2 ** (CTR_BITS - 1) - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e               state_q;
  logic [IDX_BITS-1:0]  sweep_q;
  logic                 ready_q;

  logic                 valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
  logic [31:0]          target_q [ENTRIES];
  logic [CTR_BITS-1:0]  ctr_q    [ENTRIES];

  logic [CNT_W-1:0]     branch_cnt_q, mispred_cnt_q;

  logic [IDX_BITS-1:0]  lk_idx, up_idx, wr_idx;
  logic [TAG_BITS-1:0]  lk_tag, up_tag, wr_tag;
  logic                 up_hit, wr_en, wr_valid;
  logic [31:0]          wr_target;
  logic [CTR_BITS-1:0]  wr_ctr, up_ctr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      sweep_q <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        StInit: begin
          sweep_q <= sweep_q + 1'b1;
          if (&sweep_q) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = ready_q;

  assign lk_idx = if_pc[IDX_BITS+1:2];
  assign lk_tag = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign up_idx = upd_pc[IDX_BITS+1:2];
  assign up_tag = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign pred_hit    = if_valid && ready_q && (MODE == 0) && valid_q[lk_idx] &&
                       (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && ctr_q[lk_idx][CTR_BITS-1];
  assign pred_target = pred_hit ? target_q[lk_idx] : 32'h0;

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctr = ctr_q[up_idx];

  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = up_idx;
    wr_valid  = valid_q[up_idx];
    wr_tag    = tag_q[up_idx];
    wr_target = target_q[up_idx];
    wr_ctr    = up_ctr;
    if (state_q == StInit) begin
      wr_en    = 1'b1;
      wr_idx   = sweep_q;
      wr_valid = 1'b0;
      wr_ctr   = CtrWnt;
    end else if (upd_valid && (MODE == 0)) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          wr_target = upd_target;
          wr_ctr    = (upd_uncond || up_ctr == CtrMax) ? CtrMax : up_ctr + 1'b1;
        end else begin
          wr_ctr    = (up_ctr == '0) ? '0 : up_ctr - 1'b1;
        end
      end else if (upd_taken) begin
        wr_en     = 1'b1;
        wr_valid  = 1'b1;
        wr_tag    = up_tag;
        wr_target = upd_target;
        wr_ctr    = upd_uncond ? CtrMax : CtrWt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      valid_q[wr_idx]  <= wr_valid;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      ctr_q[wr_idx]    <= wr_ctr;
    end
  end

  assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (upd_valid && !(&branch_cnt_q)) branch_cnt_q <= branch_cnt_q + 1'b1;
      if (mispredict && !(&mispred_cnt_q)) mispred_cnt_q <= mispred_cnt_q + 1'b1;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], if_pc[31:IDX_BITS+TAG_BITS+2]};

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor: a dynamic instance and a static-mode
// instance with 4-bit counters share stimulus and are compared to a table model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, upd_valid, upd_uncond, upd_taken, upd_pred_taken;
  logic [31:0] if_pc, upd_pc, upd_target, upd_pred_target;

  logic        d_ready, d_pred_hit, d_pred_taken, d_mispredict;
  logic [31:0] d_pred_target, d_redirect_pc, d_branch_cnt, d_mispred_cnt;
  logic        s_ready, s_pred_hit, s_pred_taken, s_mispredict;
  logic [31:0] s_pred_target, s_redirect_pc;
  logic [3:0]  s_branch_cnt, s_mispred_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-index entry plus counters.
  bit          mv  [64];
  int unsigned mt  [64];
  int unsigned mtg [64];
  int          mc  [64];
  longint      m_br, m_mis, s_br, s_mis;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .ready(d_ready),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_hit(d_pred_hit), .pred_taken(d_pred_taken), .pred_target(d_pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_uncond(upd_uncond),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(d_mispredict), .redirect_pc(d_redirect_pc),
    .branch_cnt(d_branch_cnt), .mispred_cnt(d_mispred_cnt)
  );

  branch_predictor #(.MODE(1), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .ready(s_ready),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_hit(s_pred_hit), .pred_taken(s_pred_taken), .pred_target(s_pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_uncond(upd_uncond),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(s_mispredict), .redirect_pc(s_redirect_pc),
    .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    m_br = 0; m_mis = 0; s_br = 0; s_mis = 0;
  endfunction

  function automatic void m_count(input bit mis);
    if (m_br < 64'hFFFF_FFFF) m_br++;
    if (s_br < 15) s_br++;
    if (mis && m_mis < 64'hFFFF_FFFF) m_mis++;
    if (mis && s_mis < 15) s_mis++;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_br"}, d_branch_cnt, m_br);
    check({tag, "_mis"}, d_mispred_cnt, m_mis);
    check({tag, "_s_br"}, s_branch_cnt, s_br);
    check({tag, "_s_mis"}, s_mispred_cnt, s_mis);
  endtask

  // Releases reset, keeps an update stream active during the sweep (table writes
  // must be dropped, statistics must still count) and measures ready latency.
  task automatic run_init();
    int cyc = 0;
    if_valid = 1'b1; if_pc = 32'h80;
    upd_valid = 1'b1; upd_pc = 32'h80; upd_uncond = 1'b0; upd_taken = 1'b1;
    upd_target = 32'h500; upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    while (!d_ready && cyc < 200) begin
      check("init_hit", d_pred_hit, 0);
      check("init_s_hit", s_pred_hit, 0);
      check("init_mis", d_mispredict, 1);
      @(posedge clk);
      cyc++;
      m_count(1'b1);
      #1;
    end
    check("ready_latency", cyc, 64);
    check("s_ready", s_ready, 1);
    check_counts("init_cnt");
    upd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply(input bit iv, input logic [31:0] ipc, input bit uv,
                       input logic [31:0] upc, input bit unc, input bit tk,
                       input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    int    li, ui;
    bit    e_hit, e_tk, e_mis, u_hit;
    logic [31:0] e_tgt, e_red;
    if_valid = iv; if_pc = ipc; upd_valid = uv; upd_pc = upc; upd_uncond = unc;
    upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
    #1;
    li    = int'(ipc[7:2]);
    e_hit = iv && mv[li] && (mt[li] == int'(ipc[15:8]));
    e_tk  = e_hit && (mc[li] >= 2);
    e_tgt = e_hit ? mtg[li] : 32'h0;
    check("pred_hit", d_pred_hit, e_hit);
    check("pred_taken", d_pred_taken, e_tk);
    check("pred_target", d_pred_target, e_tgt);
    check("s_pred_hit", s_pred_hit, 0);
    check("s_pred_taken", s_pred_taken, 0);
    check("s_pred_target", s_pred_target, 0);
    e_mis = uv && ((tk != ptk) || (tk && tgt != ptgt));
    check("mispredict", d_mispredict, e_mis);
    check("s_mispredict", s_mispredict, e_mis);
    if (e_mis) begin
      e_red = tk ? tgt : upc + 32'd4;
      check("redirect", d_redirect_pc, e_red);
      check("s_redirect", s_redirect_pc, e_red);
    end
    if (uv) begin
      m_count(e_mis);
      ui    = int'(upc[7:2]);
      u_hit = mv[ui] && (mt[ui] == int'(upc[15:8]));
      if (tk && u_hit) begin
        mc[ui]  = unc ? 3 : (mc[ui] < 3 ? mc[ui] + 1 : 3);
        mtg[ui] = tgt;
      end else if (tk) begin
        mv[ui] = 1'b1; mt[ui] = int'(upc[15:8]); mtg[ui] = tgt;
        mc[ui] = unc ? 3 : 2;
      end else if (u_hit) begin
        mc[ui] = mc[ui] > 0 ? mc[ui] - 1 : 0;
      end
    end
    @(posedge clk);
    #1;
    check_counts("cnt");
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = 32'h0;
    p[7:2]  = 6'($urandom_range(0, 7));
    p[15:8] = 8'($urandom_range(0, 2));
    return p;
  endfunction

  initial begin
    logic [31:0] pc, lpc, tgt, ptgt;
    bit tk, unc, ptk;
    rst_n = 1'b0;
    if_valid = 1'b0; if_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_uncond = 1'b0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", d_ready, 0);
    check_counts("rst_cnt");
    run_init();

    // Entry written during the sweep must not exist.
    apply(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    // First taken branch allocates and mispredicts.
    apply(0, 0, 1, 32'h40, 0, 1, 32'h80, 0, 0);
    apply(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    // Loop branch: three taken, then exit.
    for (int i = 0; i < 3; i++) apply(1, 32'h40, 1, 32'h40, 0, 1, 32'h80, 1, 32'h80);
    apply(1, 32'h40, 1, 32'h40, 0, 0, 32'h80, 1, 32'h80);
    apply(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    // Alias: 0x140 shares the index but not the tag.
    apply(0, 0, 1, 32'h140, 0, 1, 32'h300, 0, 0);
    apply(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 32'h140, 0, 0, 0, 0, 0, 0, 0);
    // jr with a changing target.
    apply(0, 0, 1, 32'h10, 1, 1, 32'h100, 0, 0);
    apply(1, 32'h10, 1, 32'h10, 1, 1, 32'h200, 1, 32'h100);
    apply(1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    // Fall-through redirect wraps at the top of the address space.
    apply(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'h8);
    // Same-cycle lookup and update to one index returns the old entry.
    apply(1, 32'h40, 1, 32'h40, 0, 0, 0, 1, 32'h80);

    for (int n = 0; n < 600; n++) begin
      pc   = rand_pc();
      lpc  = ($urandom_range(0, 3) == 0) ? pc : rand_pc();
      tk   = 1'($urandom_range(0, 1));
      unc  = ($urandom_range(0, 4) == 0);
      if (unc) tk = 1'b1;
      tgt  = 32'h100 * $urandom_range(1, 4);
      ptk  = 1'($urandom_range(0, 1));
      ptgt = ($urandom_range(0, 2) == 0) ? 32'h100 * $urandom_range(1, 4) : tgt;
      apply(1'($urandom_range(0, 1)), lpc, ($urandom_range(0, 3) != 0), pc, unc, tk, tgt,
            ptk, ptgt);
    end

    // Asynchronous reset mid-run clears counters and the table.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst2_ready", d_ready, 0);
    m_reset();
    check_counts("rst2_cnt");
    run_init();
    apply(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 32'h10, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
